regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (RDaddr/RDdata/RegWrite) between two writeback sources:
//  A = in-order pipeline WB stage, B = multicycle unit (MUL/DIV) that retires out of band.
//  B results are buffered in a small FIFO; a starvation-bounded priority arbiter picks one write per cycle.
//  Exports a per-register pending scoreboard and a read-hazard stall for ID-stage RS/RT operands.
// PARAMETERS
//  FIFO_DEPTH  2  B-side buffer entries (power of 2, >=2)
//  STARVE_MAX  4  max consecutive cycles a non-empty B FIFO may lose to A before B is forced
//  ZERO_GUARD  1  1: writes to r0 are consumed but never drive RegWrite_o
// PORTS
//  clk_i       in   1   clock, all state on posedge
//  rst_n_i     in   1   asynchronous reset, active-low
//  a_valid_i   in   1   pipeline WB write request
//  a_addr_i    in   5   pipeline destination register
//  a_data_i    in   32  pipeline write data
//  a_ready_o   out  1   A request accepted this cycle
//  b_valid_i   in   1   multicycle unit write request
//  b_addr_i    in   5   multicycle destination register
//  b_data_i    in   32  multicycle write data
//  b_ready_o   out  1   B FIFO can accept (= FIFO not full)
//  RSaddr_i    in   5   ID-stage RS operand address for hazard check
//  RTaddr_i    in   5   ID-stage RT operand address for hazard check
//  RDaddr_o    out  5   to register file write address
//  RDdata_o    out  32  to register file write data
//  RegWrite_o  out  1   to register file write enable
//  pending_o   out  32  bit r set while a write to r is queued or in the output stage
//  stall_o     out  1   RS or RT (nonzero) hits pending_o
// BEHAVIOUR
//  Reset (async, rst_n_i=0): FIFO emptied, starve counter 0, RDaddr_o=0, RDdata_o=0, RegWrite_o=0;
//   pending_o=0, stall_o=0 follow combinationally. In-flight writes are discarded, never replayed.
//  Handshake: transfer when valid&ready in the same cycle; requester holds addr/data until ready.
//  B enqueue: b_valid_i & b_ready_o pushes {addr,data}. No bypass: an entry is issuable from the next cycle.
//   Full FIFO -> b_ready_o=0, even if a pop occurs in that cycle.
//  Arbitration per cycle (head = oldest FIFO entry):
//   force_b = FIFO non-empty & starve_cnt==STARVE_MAX
//   a_ready_o = ~force_b (combinational; A accepted whenever not forced, regardless of a_valid_i)
//   grant A if a_valid_i & ~force_b; else grant head if FIFO non-empty; else idle.
//  starve_cnt: +1 when A granted while FIFO non-empty (saturates at STARVE_MAX); cleared on B grant or FIFO empty.
//  Output stage (latency 1): on grant, next edge registers RDaddr_o/RDdata_o and sets RegWrite_o=1;
//   idle cycle -> RegWrite_o=0, addr/data hold. ZERO_GUARD=1 & addr==0 -> RegWrite_o=0 (grant still consumed).
//  Write ordering: B entries retire in FIFO order; no A/B same-register ordering enforced here
//   (hazard unit uses stall_o to stop A-side producers reading stale values).
//  pending_o[r] = OR over valid FIFO entries with addr r, plus (RegWrite_o & RDaddr_o==r); bit 0 forced 0.
//  stall_o = (RSaddr_i!=0 & pending_o[RSaddr_i]) | (RTaddr_i!=0 & pending_o[RTaddr_i]); combinational.
//  Simultaneous push+pop on non-full FIFO: count unchanged, both pointers advance; pointers wrap mod FIFO_DEPTH.
// STRUCTURE
//  Shared package/include: REG_AW=5, REG_DW=32, REG_ZERO=5'd0, write-request field widths.
//  One sub-module: wb_fifo (sync FIFO, async active-low reset, exposes entry valid/addr vectors for scoreboard).
//  Top holds arbiter, starve counter, output register, scoreboard/stall logic.
// TESTING
//  A only: a_valid=1 addr=5 data=32'hDEAD -> a_ready=1; next cycle RegWrite_o=1, RDaddr_o=5, RDdata_o=32'hDEAD.
//  B only: push addr=7 data=1 -> pending_o[7]=1 same cycle as entry visible; write issues 2 cycles after push; pending_o[7] clears after.
//  Starvation: A valid every cycle, one B entry queued -> A wins 4 cycles, 5th cycle a_ready_o=0 and B issues; counter restarts.
//  Full FIFO: push 2 B entries while A saturates -> b_ready_o=0; entries retire in push order with correct data.
//  Zero guard: A writes addr 0 -> a_ready=1, RegWrite_o stays 0; RSaddr_i=0 never stalls.
//  Reset mid-op: FIFO holding 2 entries, rst_n_i low mid-cycle -> RegWrite_o, pending_o, stall_o 0 immediately; no write after release.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
// Write-request bundle plus address/data widths.
package regfile_wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wr_req_t;

  function automatic logic [31:0] reg_onehot(input reg_addr_t a);
    return 32'd1 << a;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small sync FIFO for out-of-band writeback requests.
// Exposes per-entry valid/addr so the top can build a scoreboard.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  wr_req_t               din_i,
  input  logic                  pop_i,
  output wr_req_t               dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH-1:0]      ent_valid_o,
  output reg_addr_t [DEPTH-1:0] ent_addr_o
);

  localparam int PW = $clog2(DEPTH);

  wr_req_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic [PW:0]         cnt_q, cnt_d;
  logic                do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally.
  always_comb begin
    wptr_d = wptr_q + PW'(do_push);
    rptr_d = rptr_q + PW'(do_pop);
    cnt_d  = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care until marked valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  // An entry is live if its offset from the head is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off            = PW'(i) - rptr_q;
      ent_valid_o[i] = ({1'b0, off} < cnt_q);
      ent_addr_o[i]  = mem_q[i].addr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB vs buffered MUL/DIV.
// Starvation-bounded priority, pending scoreboard, ID read stall.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4,
  parameter bit ZERO_GUARD = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              a_valid_i,
  input  logic [REG_AW-1:0] a_addr_i,
  input  logic [REG_DW-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [REG_AW-1:0] b_addr_i,
  input  logic [REG_DW-1:0] b_data_i,
  output logic              b_ready_o,
  input  logic [REG_AW-1:0] RSaddr_i,
  input  logic [REG_AW-1:0] RTaddr_i,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic [REG_DW-1:0] RDdata_o,
  output logic              RegWrite_o,
  output logic [31:0]       pending_o,
  output logic              stall_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  wr_req_t                   head, win;
  logic                      empty, full;
  logic [FIFO_DEPTH-1:0]     ent_valid;
  reg_addr_t [FIFO_DEPTH-1:0] ent_addr;
  logic                      force_b, grant_a, grant_b;
  logic [SW-1:0]             starve_q, starve_d;
  reg_addr_t                 rd_addr_q;
  reg_data_t                 rd_data_q;
  logic                      we_q;
  logic [31:0]               pend;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (b_valid_i),
    .din_i       ('{addr: b_addr_i, data: b_data_i}),
    .pop_i       (grant_b),
    .dout_o      (head),
    .empty_o     (empty),
    .full_o      (full),
    .ent_valid_o (ent_valid),
    .ent_addr_o  (ent_addr)
  );

  assign b_ready_o = ~full;
  assign force_b   = ~empty & (starve_q == SMAX);
  assign a_ready_o = ~force_b;
  assign grant_a   = a_valid_i & ~force_b;
  assign grant_b   = ~grant_a & ~empty;
  assign win       = grant_a ? '{addr: a_addr_i, data: a_data_i} : head;

  // Starve count: grows while A beats a waiting B, resets otherwise.
  always_comb begin
    starve_d = starve_q;
    if (empty || grant_b) starve_d = '0;
    else if (grant_a && starve_q != SMAX) starve_d = starve_q + 1'b1;
  end

  // Starve counter state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) starve_q <= '0;
    else          starve_q <= starve_d;
  end

  // Output stage: capture the winner, suppress enable for r0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
      we_q      <= 1'b0;
    end else if (grant_a || grant_b) begin
      rd_addr_q <= win.addr;
      rd_data_q <= win.data;
      we_q      <= !(ZERO_GUARD && win.addr == REG_ZERO);
    end else begin
      we_q      <= 1'b0;
    end
  end

  // Scoreboard: queued entries plus the write in the output stage.
  always_comb begin
    pend = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (ent_valid[i]) pend = pend | reg_onehot(ent_addr[i]);
    if (we_q) pend = pend | reg_onehot(rd_addr_q);
    pend[0] = 1'b0;
  end

  assign RDaddr_o   = rd_addr_q;
  assign RDdata_o   = rd_data_q;
  assign RegWrite_o = we_q;
  assign pending_o  = pend;
  assign stall_o    = ((RSaddr_i != REG_ZERO) & pend[RSaddr_i])
                    | ((RTaddr_i != REG_ZERO) & pend[RTaddr_i]);

endmodule
